cache_line_xfer: RTL

Memory-side line transfer engine that sits directly downstream of the cache controller FSM. It takes one line-level command: refill (read a line) or evict (write back a dirty line). It serialises the command into per-word memory requests, collects the in-order memory responses, and returns a single completion to the controller. For refills, the completion carries the assembled line. This block is the one place that handles word counting, address stepping and outstanding-request accounting, so the controller never tracks them itself.

---
 rtl/cache_line_xfer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/cache_line_xfer.sv
// rtl/cache_line_xfer.sv - serialises line refill/evict commands into per-word memory requests
// Optional CACHE_LINE_XFER_ERR_CHECK_EN adds the sticky xfer_err output.
module cache_line_xfer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WORDS  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_val,
  output logic                    cmd_rdy,
  input  logic                    cmd_type,
  input  logic [ADDR_W-1:0]       cmd_addr,
  input  logic [WORDS*DATA_W-1:0] wb_data,
  output logic                    memreq_val,
  input  logic                    memreq_rdy,
  output logic                    memreq_type,
  output logic [ADDR_W-1:0]       memreq_addr,
  output logic [DATA_W-1:0]       memreq_data,
  input  logic                    memresp_val,
  output logic                    memresp_rdy,
  input  logic [DATA_W-1:0]       memresp_data,
  output logic                    done_val,
  input  logic                    done_rdy,
  output logic                    done_type,
  output logic [WORDS*DATA_W-1:0] refill_data,
  output logic                    busy
`ifdef CACHE_LINE_XFER_ERR_CHECK_EN
  ,
  output logic                    xfer_err
`endif
);

  localparam int IW      = $clog2(WORDS);
  localparam int CW      = IW + 1;
  localparam int BYTE_SH = $clog2(DATA_W / 8);
  localparam int LINE_SH = IW + BYTE_SH;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t                        state, state_nxt;
  logic                          type_q;
  logic [ADDR_W-1:0]             base_q;
  logic [WORDS-1:0][DATA_W-1:0]  wb_q;
  logic [WORDS-1:0][DATA_W-1:0]  refill_q;
  logic [CW-1:0]                 req_cnt, resp_cnt;

  logic in_xfer, req_pending, cmd_fire, req_fire, resp_fire, resp_ok;

  // Handshake qualifiers derive from state directly to keep outputs free of input paths.
  assign in_xfer     = (state == XFER);
  assign req_pending = in_xfer && (req_cnt < CW'(WORDS));
  assign cmd_fire    = (state == IDLE) && cmd_val;
  assign req_fire    = req_pending && memreq_rdy;
  assign resp_fire   = in_xfer && memresp_val;
  assign resp_ok     = resp_fire && (resp_cnt != req_cnt);

  assign busy        = (state != IDLE);
  assign done_type   = type_q;
  assign refill_data = refill_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cmd_rdy     = 1'b0;
    memreq_val  = 1'b0;
    memreq_type = 1'b0;
    memreq_addr = '0;
    memreq_data = '0;
    memresp_rdy = 1'b0;
    done_val    = 1'b0;
    case (state)
      IDLE: begin
        cmd_rdy = 1'b1;
        if (cmd_val) state_nxt = XFER;
      end
      XFER: begin
        memresp_rdy = 1'b1;
        if (req_pending) begin
          memreq_val  = 1'b1;
          memreq_type = type_q;
          memreq_addr = base_q + (ADDR_W'(req_cnt[IW-1:0]) << BYTE_SH);
          memreq_data = type_q ? wb_q[req_cnt[IW-1:0]] : '0;
        end
        if (resp_ok && (resp_cnt == CW'(WORDS - 1))) state_nxt = DONE;
      end
      DONE: begin
        done_val = 1'b1;
        if (done_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      type_q   <= 1'b0;
      base_q   <= '0;
      wb_q     <= '0;
      refill_q <= '0;
      req_cnt  <= '0;
      resp_cnt <= '0;
    end else begin
      if (cmd_fire) begin
        type_q   <= cmd_type;
        base_q   <= {cmd_addr[ADDR_W-1:LINE_SH], {LINE_SH{1'b0}}};
        wb_q     <= wb_data;
        req_cnt  <= '0;
        resp_cnt <= '0;
      end
      if (req_fire) req_cnt <= req_cnt + 1'b1;
      if (resp_ok) begin
        resp_cnt <= resp_cnt + 1'b1;
        if (!type_q) refill_q[resp_cnt[IW-1:0]] <= memresp_data;
      end
    end
  end

`ifdef CACHE_LINE_XFER_ERR_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                           xfer_err <= 1'b0;
    else if ((resp_fire && !resp_ok) || (in_xfer && cmd_val)) xfer_err <= 1'b1;
  end
`endif

endmodule
